arilla_sram_responder: RTL

//   Single-port word-organised SRAM responder on the arilla system bus; serves read/write

---
 rtl/arilla_sram_responder_if.sv | 26 ++
 rtl/arilla_sram_responder.sv | 127 ++++++++++++
 2 files changed

// File: rtl/arilla_sram_responder_if.sv
// Arilla system bus connection between one initiator and one memory responder.
interface arilla_sram_responder_if;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned BeW   = 4;

  logic [AddrW-1:0] bus_addr;
  logic [DataW-1:0] bus_wdata;
  logic [BeW-1:0]   bus_be;
  logic             bus_rd;
  logic             bus_wr;
  logic             bus_hit;
  logic [DataW-1:0] bus_rdata;
  logic             bus_ack;
  logic             bus_fault;

  modport master (
    output bus_addr, bus_wdata, bus_be, bus_rd, bus_wr,
    input  bus_hit, bus_rdata, bus_ack, bus_fault
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_be, bus_rd, bus_wr,
    output bus_hit, bus_rdata, bus_ack, bus_fault
  );
endinterface

// File: rtl/arilla_sram_responder.sv
// Word-organised SRAM responder: window decode, programmable wait states,
// one-cycle ack pulse with fault qualifier.
module arilla_sram_responder #(
  parameter logic [31:0] BaseAddress = 32'h0000_0000,
  parameter int unsigned SizeWords   = 1024,
  parameter int unsigned WaitStates  = 1,
  parameter bit          ReadOnly    = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  arilla_sram_responder_if.slave  bus
);
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned BeW   = 4;
  localparam int unsigned CntW  = 4;
  localparam int unsigned IdxW  = (SizeWords > 1) ? $clog2(SizeWords) : 1;
  localparam logic [AddrW:0] WinBytes = (AddrW+1)'(SizeWords) * (AddrW+1)'(4);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [BeW-1:0]   be_q, be_d;
  logic [DataW-1:0] wdata_q, wdata_d;
  logic             wr_q, wr_d;
  logic             flt_q, flt_d;
  logic             ack_q, ack_d;
  logic             fault_q, fault_d;
  logic [DataW-1:0] rdata_q, rdata_d;

  logic [DataW-1:0] mem [SizeWords];
  logic [AddrW-1:0] offset;
  logic             req;
  logic [IdxW-1:0]  req_idx;
  logic             req_flt;

  // Window decode; the subtraction makes any out-of-window address a large unsigned value.
  assign offset      = bus.bus_addr - BaseAddress;
  assign bus.bus_hit = ({1'b0, offset} < WinBytes);
  assign req         = bus.bus_hit && (bus.bus_rd || bus.bus_wr);
  assign req_idx     = IdxW'(offset >> 2);
  assign req_flt     = (bus.bus_rd && bus.bus_wr) ||
                       (bus.bus_wr && (ReadOnly || (bus.bus_be == '0)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    flt_d   = flt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          idx_d   = req_idx;
          be_d    = bus.bus_be;
          wdata_d = bus.bus_wdata;
          wr_d    = bus.bus_wr;
          flt_d   = req_flt;
          if (WaitStates == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(WaitStates);
          end
        end
      end
      StWait: begin
        // Initiator abort wins over the final wait cycle.
        if (!bus.bus_rd && !bus.bus_wr) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    ack_d   = (state_d == StResp);
    fault_d = ack_d && flt_d;
    rdata_d = (ack_d && !flt_d && !wr_d) ? mem[idx_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      flt_q   <= 1'b0;
      ack_q   <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      flt_q   <= flt_d;
      ack_q   <= ack_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is not reset; a write commits at the end of its ack cycle unless reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == StResp) && wr_q && !flt_q) begin
      for (int unsigned b = 0; b < BeW; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign bus.bus_ack   = ack_q;
  assign bus.bus_fault = fault_q;
  assign bus.bus_rdata = rdata_q;
endmodule
